// File: rtl/i2c_target.sv
// I2C target engine: START/STOP detect, 7-bit address match, byte write/read.
// Optional define I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample filter on SCL/SDA.
module i2c_target #(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       nack_seen
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR,
        S_WR_ACK,
        S_RD,
        S_RD_ACK,
        S_WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   w_scl_s;
    logic                   w_sda_s;
    logic                   w_scl;
    logic                   w_sda;
    logic                   r_scl_d;
    logic                   r_sda_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
        end
    end

    assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [2:0] r_scl_h;
    logic [2:0] r_sda_h;
    logic       r_scl_f;
    logic       r_sda_f;

    // filtered level moves only after three agreeing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_h <= 3'b111;
            r_sda_h <= 3'b111;
            r_scl_f <= 1'b1;
            r_sda_f <= 1'b1;
        end else begin
            r_scl_h <= {r_scl_h[1:0], w_scl_s};
            r_sda_h <= {r_sda_h[1:0], w_sda_s};
            if (r_scl_h == 3'b111)
                r_scl_f <= 1'b1;
            else if (r_scl_h == 3'b000)
                r_scl_f <= 1'b0;
            if (r_sda_h == 3'b111)
                r_sda_f <= 1'b1;
            else if (r_sda_h == 3'b000)
                r_sda_f <= 1'b0;
        end
    end

    assign w_scl = r_scl_f;
    assign w_sda = r_sda_f;
`else
    assign w_scl = w_scl_s;
    assign w_sda = w_sda_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

    state_t      r_state;
    state_t      w_state_nx;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nx;
    logic [6:0]  r_shift;
    logic [6:0]  w_shift_nx;
    logic        r_rw;
    logic        w_rw_nx;
    logic        r_ack_on;
    logic        w_ack_on_nx;
    logic        r_load;
    logic        w_load_nx;
    logic        r_oe;
    logic        w_oe_nx;
    logic        r_busy;
    logic        w_busy_nx;
    logic [7:0]  r_rx_data;
    logic [7:0]  w_rx_data_nx;
    logic        r_rx_valid;
    logic        w_rx_valid_nx;
    logic        r_tx_req;
    logic        w_tx_req_nx;
    logic        r_nack;
    logic        w_nack_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_shift    <= 7'd0;
            r_rw       <= 1'b0;
            r_ack_on   <= 1'b0;
            r_load     <= 1'b0;
            r_oe       <= 1'b0;
            r_busy     <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_nack     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_shift    <= w_shift_nx;
            r_rw       <= w_rw_nx;
            r_ack_on   <= w_ack_on_nx;
            r_load     <= w_load_nx;
            r_oe       <= w_oe_nx;
            r_busy     <= w_busy_nx;
            r_rx_data  <= w_rx_data_nx;
            r_rx_valid <= w_rx_valid_nx;
            r_tx_req   <= w_tx_req_nx;
            r_nack     <= w_nack_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_shift_nx    = r_shift;
        w_rw_nx       = r_rw;
        w_ack_on_nx   = r_ack_on;
        w_load_nx     = r_load;
        w_oe_nx       = r_oe;
        w_busy_nx     = r_busy;
        w_rx_data_nx  = r_rx_data;
        w_rx_valid_nx = 1'b0;
        w_tx_req_nx   = 1'b0;
        w_nack_nx     = 1'b0;
        if (w_start || w_stop) begin
            w_state_nx  = w_start ? S_ADDR : S_IDLE;
            w_cnt_nx    = 3'd0;
            w_oe_nx     = 1'b0;
            w_busy_nx   = 1'b0;
            w_ack_on_nx = 1'b0;
            w_load_nx   = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                end
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nx = {r_shift[5:0], w_sda};
                        w_cnt_nx   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            if (r_shift == ADDR) begin
                                w_state_nx = S_ADDR_ACK;
                                w_rw_nx    = w_sda;
                            end else begin
                                w_state_nx = S_WAIT_STOP;
                            end
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_ack_on) begin
                            w_oe_nx     = 1'b1;
                            w_busy_nx   = 1'b1;
                            w_ack_on_nx = 1'b1;
                            w_tx_req_nx = r_rw;
                        end else begin
                            w_ack_on_nx = 1'b0;
                            w_cnt_nx    = 3'd0;
                            if (r_rw) begin
                                // first read bit goes out on the fall ending the ACK
                                w_shift_nx = tx_data[6:0];
                                w_oe_nx    = ~tx_data[7];
                                w_state_nx = S_RD;
                            end else begin
                                w_oe_nx    = 1'b0;
                                w_state_nx = S_WR;
                            end
                        end
                    end
                end
                S_WR: begin
                    if (w_scl_rise) begin
                        w_shift_nx = {r_shift[5:0], w_sda};
                        w_cnt_nx   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_rx_data_nx  = {r_shift, w_sda};
                            w_rx_valid_nx = 1'b1;
                            w_state_nx    = S_WR_ACK;
                        end
                    end
                end
                S_WR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_ack_on) begin
                            w_oe_nx     = 1'b1;
                            w_ack_on_nx = 1'b1;
                        end else begin
                            w_oe_nx     = 1'b0;
                            w_ack_on_nx = 1'b0;
                            w_cnt_nx    = 3'd0;
                            w_state_nx  = S_WR;
                        end
                    end
                end
                S_RD: begin
                    if (w_scl_fall) begin
                        if (r_load) begin
                            w_shift_nx = tx_data[6:0];
                            w_oe_nx    = ~tx_data[7];
                            w_cnt_nx   = 3'd0;
                            w_load_nx  = 1'b0;
                        end else if (r_cnt == 3'd7) begin
                            w_oe_nx    = 1'b0;
                            w_state_nx = S_RD_ACK;
                        end else begin
                            w_oe_nx    = ~r_shift[6];
                            w_shift_nx = {r_shift[5:0], 1'b0};
                            w_cnt_nx   = r_cnt + 3'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (w_scl_rise) begin
                        if (!w_sda) begin
                            w_tx_req_nx = 1'b1;
                            w_load_nx   = 1'b1;
                            w_state_nx  = S_RD;
                        end else begin
                            w_nack_nx  = 1'b1;
                            w_state_nx = S_WAIT_STOP;
                        end
                    end
                end
                S_WAIT_STOP: begin
                    w_oe_nx = 1'b0;
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_oe_nx    = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe    = r_oe;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign tx_req    = r_tx_req;
    assign busy      = r_busy;
    assign nack_seen = r_nack;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus-master model with rx/read scoreboards.
// Glitch case is built only when I2C_TARGET_GLITCH_FILTER_EN is defined.
module tb_i2c_target;

    localparam int H = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'hFF;
    logic       tx_req;
    logic       busy;
    logic       nack_seen;
    logic       sda_line;

    assign sda_line = m_sda & ~sda_oe;
    assign scl_in   = m_scl;
    assign sda_in   = sda_line;

    i2c_target #(.ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .busy      (busy),
        .nack_seen (nack_seen)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_rxv = 0;
    int n_rx_push = 0;
    int n_txr = 0;
    int n_nack = 0;
    logic oe_seen = 1'b0;
    logic busy_seen = 1'b0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_rd[$];
    logic [7:0] txq[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                n_rxv++;
                if (exp_rx.size() == 0)
                    chk("rx_unexp", 32'(n_rxv), 32'(n_rx_push));
                else
                    chk("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
            end
            if (tx_req) begin
                n_txr++;
                tx_data = (txq.size() != 0) ? txq.pop_front() : 8'hFF;
                exp_rd.push_back(tx_data);
            end
            if (nack_seen) n_nack++;
            if (sda_oe) oe_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_rx(input logic [7:0] d);
        exp_rx.push_back(d);
        n_rx_push++;
    endtask

    task automatic bus_start();
        m_sda = 1'b1; m_scl = 1'b1; wait_clk(H);
        m_sda = 1'b0; wait_clk(H);
        m_scl = 1'b0;
    endtask

    task automatic bus_rstart();
        wait_clk(H/2); m_sda = 1'b1;
        wait_clk(H/2); m_scl = 1'b1;
        wait_clk(H/2); m_sda = 1'b0;
        wait_clk(H/2); m_scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(H/2); m_sda = 1'b0;
        wait_clk(H/2); m_scl = 1'b1;
        wait_clk(H/2); m_sda = 1'b1;
        wait_clk(H);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        wait_clk(H/2); m_sda = b;
        wait_clk(H/2); m_scl = 1'b1;
        if (glitch) begin
            wait_clk(H/2); m_scl = 1'b0;
            wait_clk(1);   m_scl = 1'b1;
            wait_clk(H/2 - 1);
        end else begin
            wait_clk(H);
        end
        m_scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wait_clk(H);
        m_scl = 1'b1; wait_clk(H/2);
        b = sda_line; wait_clk(H/2);
        m_scl = 1'b0;
    endtask

    task automatic wbyte(input logic [7:0] d, input int gbit,
                         output logic ack);
        for (int i = 7; i >= 0; i--)
            send_bit(d[i], i == gbit);
        read_bit(ack);
    endtask

    task automatic rd_check(input logic nack_bit);
        logic [7:0] d;
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        if (exp_rd.size() == 0)
            chk("rd_noexp", 32'(n_txr), 32'(n_txr + 1));
        else
            chk("rd_byte", 32'(d), 32'(exp_rd.pop_front()));
        wait_clk(8);
        chk("rd_rel", 32'(sda_oe), 0);
        send_bit(nack_bit, 1'b0);
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        logic ack;
        int   rxv0;
        int   t;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(1);
        chk("rst_oe", 32'(sda_oe), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_tx_req", 32'(tx_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_nack", 32'(nack_seen), 0);
        wait_clk(H);

        // write of one byte
        rxv0 = n_rxv;
        bus_start();
        wbyte(8'h84, -1, ack);
        chk("wr_addr_ack", 32'(ack), 0);
        chk("wr_busy", 32'(busy), 1);
        push_rx(8'hA5);
        wbyte(8'hA5, -1, ack);
        chk("wr_data_ack", 32'(ack), 0);
        bus_stop();
        chk("wr_busy_stop", 32'(busy), 0);
        chk("wr_rxv_cnt", 32'(n_rxv - rxv0), 1);
        chk("wr_rx_hold", 32'(rx_data), 32'h A5);

        // address mismatch
        rxv0 = n_rxv;
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        bus_start();
        wbyte(8'h86, -1, ack);
        chk("mm_addr_ack", 32'(ack), 1);
        wbyte(8'hA5, -1, ack);
        chk("mm_data_ack", 32'(ack), 1);
        bus_stop();
        chk("mm_oe_seen", 32'(oe_seen), 0);
        chk("mm_busy_seen", 32'(busy_seen), 0);
        chk("mm_rxv_cnt", 32'(n_rxv - rxv0), 0);

        // read of two bytes, ACK then NACK
        n_txr = 0;
        n_nack = 0;
        txq.push_back(8'h3C);
        txq.push_back(8'hC3);
        bus_start();
        wbyte(8'h85, -1, ack);
        chk("rd_addr_ack", 32'(ack), 0);
        rd_check(1'b0);
        rd_check(1'b1);
        bus_stop();
        chk("rd_txreq_cnt", 32'(n_txr), 2);
        chk("rd_nack_cnt", 32'(n_nack), 1);
        chk("rd_oe_end", 32'(sda_oe), 0);

        // repeated START after 4 write data bits
        rxv0 = n_rxv;
        bus_start();
        wbyte(8'h84, -1, ack);
        chk("rs_addr_ack", 32'(ack), 0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        bus_rstart();
        wait_clk(4);
        chk("rs_oe", 32'(sda_oe), 0);
        chk("rs_busy", 32'(busy), 0);
        txq.push_back(8'h5A);
        wbyte(8'h85, -1, ack);
        chk("rs_addr2_ack", 32'(ack), 0);
        rd_check(1'b1);
        bus_stop();
        chk("rs_rxv_cnt", 32'(n_rxv - rxv0), 0);

        // reset while the address ACK is driven
        rxv0 = n_rxv;
        bus_start();
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] a;
            a = 8'h84;
            send_bit(a[i], 1'b0);
        end
        m_sda = 1'b1;
        t = 0;
        while (!sda_oe && t < 40) begin
            wait_clk(1);
            t++;
        end
        chk("rr_ack_drv", 32'(sda_oe), 1);
        rst = 1'b1;
        wait_clk(1);
        chk("rr_oe_rel", 32'(sda_oe), 0);
        rst = 1'b0;
        wait_clk(H - t - 1);
        m_scl = 1'b1; wait_clk(H);
        m_scl = 1'b0;
        oe_seen = 1'b0;
        wbyte(8'hA5, -1, ack);
        chk("rr_ignored_ack", 32'(ack), 1);
        chk("rr_oe_seen", 32'(oe_seen), 0);
        chk("rr_rxv_cnt", 32'(n_rxv - rxv0), 0);
        bus_rstart();
        wbyte(8'h84, -1, ack);
        chk("rr_fresh_ack", 32'(ack), 0);
        push_rx(8'h5A);
        wbyte(8'h5A, -1, ack);
        chk("rr_data_ack", 32'(ack), 0);
        bus_stop();

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // 1-clk SCL low glitch inside bit 4 of a data byte
        bus_start();
        wbyte(8'h84, -1, ack);
        chk("gl_addr_ack", 32'(ack), 0);
        push_rx(8'h96);
        wbyte(8'h96, 4, ack);
        chk("gl_data_ack", 32'(ack), 0);
        bus_stop();
`endif

        wait_clk(10);
        chk("rx_drain", 32'(exp_rx.size()), 0);
        chk("rd_drain", 32'(exp_rd.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
